// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave datapath: frame states, SPI mode
// constants shared with the SCLK edge detector, and counter sizing.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

  localparam logic CPOL_IDLE_LOW     = 1'b0;
  localparam logic CPOL_IDLE_HIGH    = 1'b1;
  localparam logic CPHA_LEAD_SAMPLE  = 1'b0;
  localparam logic CPHA_TRAIL_SAMPLE = 1'b1;

  // A one-bit counter is still needed for the smallest legal word length.
  function automatic int bit_cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_tx_buffer.sv
// One-entry transmit holding buffer with a ready/valid write port and
// underrun detection on every load request from the frame controller.
module spi_tx_buffer
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              load,
  output logic [DATA_W-1:0] load_word,
  output logic              tx_underrun
);

  logic [DATA_W-1:0] buf_data;
  logic              buf_full;
  logic              wr_en;

  assign wr_en     = tx_valid && !buf_full;
  assign tx_ready  = !buf_full;
  assign load_word = buf_full ? buf_data : '0;

  // A write is only accepted while empty, so it can never collide with a
  // load that drains a full buffer; a load on an empty buffer underruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data    <= '0;
      buf_full    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load && !buf_full;
      if (wr_en) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame controller: sequences a full-duplex frame from the edge
// detector strobes, deserializes MOSI and serializes buffered words to MISO.
module spi_slave_frame_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CPHA      = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sampl_en,
  input  logic              shift_en,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_abort
);

  localparam int              CNT_W         = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(DATA_W - 1);
  localparam bit              LOAD_ON_START = (CPHA == int'(CPHA_LEAD_SAMPLE));

  frame_state_t      state, state_nxt;
  logic              entering, leaving, active;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_inc, cnt_after_sample;
  logic [DATA_W-1:0] rx_sr, rx_shifted;
  logic [DATA_W-1:0] tx_sr, tx_shifted, load_word;
  logic              sample, word_done, tx_step, load, shift;
  logic              first_bit, next_bit;

  always_comb begin
    state_nxt = state;
    entering  = 1'b0;
    leaving   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_n) begin
          state_nxt = ST_ACTIVE;
          entering  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_n) begin
          state_nxt = ST_IDLE;
          leaving   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign active  = (state == ST_ACTIVE);
  assign miso_oe = active;

  // The shift strobe sees the counter as already advanced by a coincident
  // sample, so word boundaries are judged on the post-sample count.
  always_comb begin
    sample           = active && sampl_en;
    word_done        = sample && (bit_cnt == LAST_BIT);
    bit_cnt_inc      = word_done ? '0 : bit_cnt + 1'b1;
    cnt_after_sample = sample ? bit_cnt_inc : bit_cnt;
    tx_step          = active && shift_en;
    load             = (LOAD_ON_START && frame_start && active) ||
                       (tx_step && (cnt_after_sample == '0));
    shift            = tx_step && (cnt_after_sample != '0);
    if (MSB_FIRST != 0) begin
      rx_shifted = {rx_sr[DATA_W-2:0], mosi};
      tx_shifted = {tx_sr[DATA_W-2:0], 1'b0};
      first_bit  = load_word[DATA_W-1];
      next_bit   = tx_sr[DATA_W-2];
    end else begin
      rx_shifted = {mosi, rx_sr[DATA_W-1:1]};
      tx_shifted = {1'b0, tx_sr[DATA_W-1:1]};
      first_bit  = load_word[0];
      next_bit   = tx_sr[1];
    end
  end

  // Leaving a frame discards any partial word, but the last complete word
  // stays visible in rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) rx_data <= rx_shifted;
      if (leaving) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt_inc;
        rx_sr   <= rx_shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_start <= entering;
      frame_end   <= leaving;
      frame_abort <= leaving && (bit_cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
      miso  <= 1'b0;
    end else if (load) begin
      tx_sr <= load_word;
      miso  <= first_bit;
    end else if (shift) begin
      tx_sr <= tx_shifted;
      miso  <= next_bit;
    end
  end

  spi_tx_buffer #(
    .DATA_W (DATA_W)
  ) u_tx_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .load        (load),
    .load_word   (load_word),
    .tx_underrun (tx_underrun)
  );

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Directed and randomized frames against a word-level model of the SPI slave,
// using a CPHA=1/MSB-first instance and a CPHA=0/LSB-first instance.
module tb_spi_slave_frame_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sampl_en = 1'b0;
  logic shift_en = 1'b0;
  logic mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic mode = 1'b1;

  logic cs_n_a, cs_n_b, tx_valid_a, tx_valid_b;
  logic miso_a, miso_oe_a, tx_ready_a, rx_valid_a, tx_underrun_a;
  logic frame_start_a, frame_end_a, frame_abort_a;
  logic miso_b, miso_oe_b, tx_ready_b, rx_valid_b, tx_underrun_b;
  logic frame_start_b, frame_end_b, frame_abort_b;
  logic [W-1:0] rx_data_a, rx_data_b;

  logic miso, miso_oe, tx_ready, rx_valid, tx_underrun;
  logic frame_start, frame_end, frame_abort;
  logic [W-1:0] rx_data;

  assign cs_n_a      = mode ? cs_n : 1'b1;
  assign cs_n_b      = mode ? 1'b1 : cs_n;
  assign tx_valid_a  = mode & tx_valid;
  assign tx_valid_b  = ~mode & tx_valid;
  assign miso        = mode ? miso_a : miso_b;
  assign miso_oe     = mode ? miso_oe_a : miso_oe_b;
  assign tx_ready    = mode ? tx_ready_a : tx_ready_b;
  assign rx_valid    = mode ? rx_valid_a : rx_valid_b;
  assign tx_underrun = mode ? tx_underrun_a : tx_underrun_b;
  assign frame_start = mode ? frame_start_a : frame_start_b;
  assign frame_end   = mode ? frame_end_a : frame_end_b;
  assign frame_abort = mode ? frame_abort_a : frame_abort_b;
  assign rx_data     = mode ? rx_data_a : rx_data_b;

  spi_slave_frame_ctrl #(.DATA_W(W), .CPHA(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_a), .sampl_en(sampl_en),
    .shift_en(shift_en), .mosi(mosi), .miso(miso_a), .miso_oe(miso_oe_a),
    .tx_data(tx_data), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_underrun(tx_underrun_a),
    .frame_start(frame_start_a), .frame_end(frame_end_a),
    .frame_abort(frame_abort_a)
  );

  spi_slave_frame_ctrl #(.DATA_W(W), .CPHA(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_b), .sampl_en(sampl_en),
    .shift_en(shift_en), .mosi(mosi), .miso(miso_b), .miso_oe(miso_oe_b),
    .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_underrun(tx_underrun_b),
    .frame_start(frame_start_b), .frame_end(frame_end_b),
    .frame_abort(frame_abort_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_rx = 0, n_start = 0, n_end = 0, n_abort = 0, n_under = 0, n_abort_alone = 0;
  logic [W-1:0] rx_seen[$];
  logic [W-1:0] feed_q[$];
  logic [W-1:0] tx_words[$];
  logic [W-1:0] mosi_words[$];
  logic         miso_seen[$];
  logic [W-1:0] last_rx[2] = '{default: '0};

  // Pulse monitor on the selected instance.
  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      n_rx++;
      rx_seen.push_back(rx_data);
    end
    if (frame_start) n_start++;
    if (frame_end) n_end++;
    if (frame_abort) n_abort++;
    if (frame_abort && !frame_end) n_abort_alone++;
    if (tx_underrun) n_under++;
  end

  // Offers queued words; a word is retired once the buffer was ready at the edge.
  initial begin
    logic last_ready;
    last_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid && last_ready && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = feed_q[0];
      end else begin
        tx_valid = 1'b0;
      end
      last_ready = tx_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bitOf(input logic [W-1:0] w, input int j, input logic msb);
    return msb ? w[W-1-j] : w[j];
  endfunction

  function automatic logic [W-1:0] txSrc(input int k);
    return (k < tx_words.size()) ? tx_words[k] : '0;
  endfunction

  task automatic spi_bit(input logic m, output logic seen);
    if (mode) begin
      shift_en = 1'b1; tick(1); shift_en = 1'b0; tick(2);
      mosi = m; sampl_en = 1'b1; seen = miso; tick(1); sampl_en = 1'b0; tick(1);
    end else begin
      mosi = m; sampl_en = 1'b1; seen = miso; tick(1); sampl_en = 1'b0; tick(2);
      shift_en = 1'b1; tick(1); shift_en = 1'b0; tick(1);
    end
  endtask

  // Runs one frame of nbits and checks it against the word-level model.
  task automatic applyStimulus(input int nbits);
    int nwords, rem, loads, under_exp, nchk;
    int s_rx, s_start, s_end, s_abort, s_under;
    logic seen;
    logic [W-1:0] mw, obs_w, exp_w, exp_rx;
    s_rx = n_rx; s_start = n_start; s_end = n_end; s_abort = n_abort; s_under = n_under;
    rx_seen.delete();
    miso_seen.delete();
    nwords = nbits / W;
    rem    = nbits % W;
    loads  = mode ? (nbits + W - 1) / W : 1 + nwords;
    foreach (tx_words[i]) feed_q.push_back(tx_words[i]);
    tick(3);
    cs_n = 1'b0;
    tick(1);
    checkOutput("frame_start", frame_start, 1);
    checkOutput("miso_oe_on", miso_oe, 1);
    tick(1);
    if (!mode) checkOutput("cpha0_first_bit", miso, bitOf(txSrc(0), 0, 1'b0));
    tick(1);
    for (int b = 0; b < nbits; b++) begin
      mw = (b / W < mosi_words.size()) ? mosi_words[b / W] : '0;
      spi_bit(bitOf(mw, b % W, mode), seen);
      miso_seen.push_back(seen);
    end
    tick(2);
    cs_n = 1'b1;
    tick(1);
    checkOutput("frame_end", frame_end, 1);
    checkOutput("frame_abort_flag", frame_abort, (rem != 0));
    checkOutput("miso_oe_off", miso_oe, 0);
    tick(3);
    for (int k = 0; k < (nbits + W - 1) / W; k++) begin
      obs_w = '0;
      exp_w = '0;
      for (int j = 0; j < W && k * W + j < nbits; j++) begin
        obs_w[j] = miso_seen[k * W + j];
        exp_w[j] = bitOf(txSrc(k), j, mode);
      end
      checkOutput($sformatf("miso_word%0d", k), obs_w, exp_w);
    end
    checkOutput("rx_valid_count", n_rx - s_rx, nwords);
    nchk = (rx_seen.size() < nwords) ? rx_seen.size() : nwords;
    for (int k = 0; k < nchk; k++)
      checkOutput($sformatf("rx_word%0d", k), rx_seen[k], mosi_words[k]);
    exp_rx = (nwords > 0) ? mosi_words[nwords - 1] : last_rx[int'(mode)];
    checkOutput("rx_data_hold", rx_data, exp_rx);
    last_rx[int'(mode)] = exp_rx;
    under_exp = (loads > tx_words.size()) ? loads - tx_words.size() : 0;
    checkOutput("underrun_count", n_under - s_under, under_exp);
    checkOutput("start_count", n_start - s_start, 1);
    checkOutput("end_count", n_end - s_end, 1);
    checkOutput("abort_count", n_abort - s_abort, (rem != 0));
    checkOutput("abort_alone", n_abort_alone, 0);
    checkOutput("tx_ready_idle", tx_ready, 1);
    checkOutput("feed_drained", feed_q.size(), 0);
    if (!mode && rem == 0) checkOutput("cpha0_trailing_miso", miso, bitOf(txSrc(nwords), 0, 1'b0));
  endtask

  initial begin
    int s_end, s_abort, nw, rem, loads, ntx;
    logic seen;
    $display("[TB] reset checks");
    tick(2);
    checkOutput("rst_miso_a", miso_a, 0);
    checkOutput("rst_miso_oe_a", miso_oe_a, 0);
    checkOutput("rst_tx_ready_a", tx_ready_a, 1);
    checkOutput("rst_tx_ready_b", tx_ready_b, 1);
    checkOutput("rst_rx_data_a", rx_data_a, 0);
    checkOutput("rst_pulses_b", {rx_valid_b, tx_underrun_b, frame_start_b, frame_end_b, frame_abort_b}, 0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] CPHA=1 word exchange");
    mode = 1'b1;
    tx_words = '{8'hA5};
    mosi_words = '{8'h3C};
    applyStimulus(8);

    $display("[TB] CPHA=0 first bit and trailing load");
    mode = 1'b0;
    tx_words = '{8'h81, 8'h7E};
    mosi_words = '{W'($urandom)};
    applyStimulus(8);

    $display("[TB] back-to-back words");
    mode = 1'b1;
    tx_words = '{8'h11, 8'h22, 8'h33};
    mosi_words = '{W'($urandom), W'($urandom), W'($urandom)};
    applyStimulus(24);

    $display("[TB] underrun");
    tx_words.delete();
    mosi_words = '{W'($urandom)};
    applyStimulus(8);

    $display("[TB] aborted frame");
    mosi_words = '{W'($urandom)};
    applyStimulus(5);
    mosi_words = '{8'hF0};
    applyStimulus(8);

    $display("[TB] reset mid-frame");
    s_end = n_end;
    s_abort = n_abort;
    feed_q.push_back(8'hFF);
    tick(3);
    cs_n = 1'b0;
    tick(3);
    for (int b = 0; b < 4; b++) spi_bit(b[0], seen);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_miso", miso, 0);
    checkOutput("midrst_miso_oe", miso_oe, 0);
    checkOutput("midrst_tx_ready", tx_ready, 1);
    checkOutput("midrst_rx_data", rx_data, 0);
    checkOutput("midrst_pulses", {rx_valid, tx_underrun, frame_start, frame_end, frame_abort}, 0);
    cs_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checkOutput("midrst_no_end", n_end - s_end, 0);
    checkOutput("midrst_no_abort", n_abort - s_abort, 0);
    last_rx[0] = '0;
    last_rx[1] = '0;
    tx_words.delete();
    mosi_words = '{8'h5A};
    applyStimulus(8);

    $display("[TB] randomized frames");
    repeat (6) begin
      mode = 1'($urandom_range(0, 1));
      nw   = $urandom_range(1, 3);
      rem  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
      loads = mode ? nw + (rem != 0) : 1 + nw;
      ntx  = $urandom_range(0, loads);
      mosi_words.delete();
      tx_words.delete();
      for (int i = 0; i <= nw; i++) mosi_words.push_back(W'($urandom));
      for (int i = 0; i < ntx; i++) tx_words.push_back(W'($urandom));
      applyStimulus(nw * W + rem);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
